relu_pool_store: RTL and testbench

- Downstream of the output buffer's 16-bit store path; consumes LANES-wide beats of saturated Q4.12 conv results.
- Applies optional ReLU and 2x2 max-pooling (stride 2), then emits pooled beats with a feature-map write address for the on-chip feature memory.
- Holds even rows in an internal line buffer and pairs them with the following odd row; one pooled beat is produced per odd-row input beat.

---
 rtl/relu_pool_store.sv | 168 ++++++++++++++++
 tb/tb_relu_pool_store.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_pool_store.sv
// relu_pool_store: optional ReLU + 2x2 stride-2 max-pool of Q4.12 conv beats, with feature-map write addressing.
// Latency: one pooled beat per odd-row input beat, registered 1 cycle after acceptance; even rows produce no output.
// Backpressure: in_rdy drops while a pooled beat is held and out_rdy is low; out_vld/out_data/out_addr hold until out_rdy.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse in IDLE; latches relu_en/row_beats/num_rows/base_addr
//   in_vld/in_rdy     input beat handshake, in_data lane j at [j*DW +: DW]
//   out_vld/out_rdy   pooled beat handshake, out_data lane k at [k*DW +: DW], out_addr its write address
//   busy              high while a tile is running or draining
//   done              one-cycle pulse when the last pooled beat of the tile has been taken

module relu_pool_store #(
   parameter int LANES     = 8,
   parameter int DW        = 16,
   parameter int MAX_BEATS = 16,
   parameter int ADDR_W    = 12
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          relu_en,
   input  logic [$clog2(MAX_BEATS):0]    row_beats,
   input  logic [9:0]                    num_rows,
   input  logic [ADDR_W-1:0]             base_addr,
   input  logic                          in_vld,
   output logic                          in_rdy,
   input  logic [LANES*DW-1:0]           in_data,
   output logic                          out_vld,
   input  logic                          out_rdy,
   output logic [LANES/2*DW-1:0]         out_data,
   output logic [ADDR_W-1:0]             out_addr,
   output logic                          busy,
   output logic                          done
);

   localparam int HL = LANES / 2;
   localparam int PW = HL * DW;
   localparam int BW = $clog2(MAX_BEATS);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t              state_q;
   logic                relu_q;
   logic [BW:0]         row_beats_q;
   logic [9:0]          num_rows_q;
   logic [ADDR_W-1:0]   base_q;
   logic [BW-1:0]       beat_cnt_q;
   logic [9:0]          row_cnt_q;
   logic [ADDR_W-1:0]   addr_cnt_q;
   logic                out_vld_q;
   logic [PW-1:0]       out_data_q;
   logic [ADDR_W-1:0]   out_addr_q;
   logic                done_q;

   // Even-row horizontal maxima, waiting for the matching odd row.
   logic [PW-1:0]       linebuf_q [MAX_BEATS];

   logic                accept;
   logic                beat_last;
   logic                row_last;
   logic                odd_row;
   logic [BW-1:0]       beat_cnt_d;
   logic [PW-1:0]       lb_rd;
   logic [PW-1:0]       h_d;
   logic [PW-1:0]       pool_d;

   function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return ($signed(a) > $signed(b)) ? a : b;
   endfunction

   function automatic logic [DW-1:0] relu_f(input logic [DW-1:0] v, input logic en);
      return (en && v[DW-1]) ? '0 : v;
   endfunction

   assign in_rdy     = (state_q == S_RUN) & (~out_vld_q | out_rdy);
   assign accept     = in_vld & in_rdy;
   assign odd_row    = row_cnt_q[0];
   assign beat_last  = ({1'b0, beat_cnt_q} == (row_beats_q - (BW+1)'(1)));
   assign row_last   = (row_cnt_q == (num_rows_q - 10'd1));
   assign beat_cnt_d = beat_last ? '0 : beat_cnt_q + BW'(1);
   assign lb_rd      = linebuf_q[beat_cnt_q];

   // Horizontal pair max, then vertical max against the buffered even row.
   always_comb begin
      h_d    = '0;
      pool_d = '0;
      for (int k = 0; k < HL; k++) begin
         h_d[k*DW +: DW]    = smax(relu_f(in_data[(2*k)*DW +: DW], relu_q),
                                   relu_f(in_data[(2*k+1)*DW +: DW], relu_q));
         pool_d[k*DW +: DW] = smax(h_d[k*DW +: DW], lb_rd[k*DW +: DW]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         relu_q      <= 1'b0;
         row_beats_q <= '0;
         num_rows_q  <= '0;
         base_q      <= '0;
         beat_cnt_q  <= '0;
         row_cnt_q   <= '0;
         addr_cnt_q  <= '0;
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // A same-cycle load below overrides this clear.
         if (out_vld_q && out_rdy) begin
            out_vld_q <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  relu_q      <= relu_en;
                  row_beats_q <= row_beats;
                  num_rows_q  <= num_rows;
                  base_q      <= base_addr;
                  beat_cnt_q  <= '0;
                  row_cnt_q   <= '0;
                  addr_cnt_q  <= '0;
                  state_q     <= S_RUN;
               end
            end
            S_RUN: begin
               if (accept) begin
                  beat_cnt_q <= beat_cnt_d;
                  if (beat_last) begin
                     row_cnt_q <= row_cnt_q + 10'd1;
                  end
                  if (odd_row) begin
                     out_vld_q  <= 1'b1;
                     out_data_q <= pool_d;
                     out_addr_q <= base_q + addr_cnt_q;
                     addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
                  end
                  if (beat_last && row_last) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (!out_vld_q || out_rdy) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !odd_row) begin
         linebuf_q[beat_cnt_q] <= h_d;
      end
   end

   assign out_vld  = out_vld_q;
   assign out_data = out_data_q;
   assign out_addr = out_addr_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;

endmodule

// File: tb/tb_relu_pool_store.sv
// tb_relu_pool_store: drives directed and random tiles into relu_pool_store and scores the pooled output stream.
// Reference computes each pooled pixel directly as the max over its 2x2 window of (optionally ReLU'd) inputs.
// Inputs are driven on the falling edge; outputs are sampled 1 ns later.

module tb_relu_pool_store;

   localparam int LANES     = 8;
   localparam int DW        = 16;
   localparam int MAX_BEATS = 16;
   localparam int ADDR_W    = 12;
   localparam int HL        = LANES / 2;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     start;
   logic                     relu_en;
   logic [4:0]               row_beats;
   logic [9:0]               num_rows;
   logic [ADDR_W-1:0]        base_addr;
   logic                     in_vld;
   logic                     in_rdy;
   logic [LANES*DW-1:0]      in_data;
   logic                     out_vld;
   logic                     out_rdy;
   logic [HL*DW-1:0]         out_data;
   logic [ADDR_W-1:0]        out_addr;
   logic                     busy;
   logic                     done;

   always #5 clk = ~clk;

   relu_pool_store #(
      .LANES(LANES), .DW(DW), .MAX_BEATS(MAX_BEATS), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
      .row_beats(row_beats), .num_rows(num_rows), .base_addr(base_addr),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_addr(out_addr),
      .busy(busy), .done(done)
   );

   int checks = 0;
   int errors = 0;

   logic [LANES*DW-1:0] tile_beats[$];
   logic [HL*DW-1:0]    exp_d[$];
   logic [ADDR_W-1:0]   exp_a[$];
   logic [HL*DW-1:0]    obs_d[$];
   logic [ADDR_W-1:0]   obs_a[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   function automatic logic signed [DW-1:0] rl(input logic [DW-1:0] v, input bit en);
      return (en && v[DW-1]) ? '0 : v;
   endfunction

   function automatic logic [DW-1:0] lane_of(input logic [LANES*DW-1:0] w, input int j);
      return w[j*DW +: DW];
   endfunction

   function automatic logic [DW-1:0] rand_lane();
      case ($urandom % 5)
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return 16'h0000;
         3:       return 16'($urandom_range(0, 15)) - 16'd8;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic fill_rand(input int rb, input int nr);
      logic [LANES*DW-1:0] w;
      tile_beats.delete();
      for (int i = 0; i < rb * nr; i++) begin
         for (int j = 0; j < LANES; j++) w[j*DW +: DW] = rand_lane();
         tile_beats.push_back(w);
      end
   endtask

   // Each pooled pixel is the max of its 2x2 window: rows (r-1, r), lanes (2k, 2k+1).
   task automatic build_expected(input bit relu, input int rb, input int nr, input logic [ADDR_W-1:0] base);
      int n;
      n = 0;
      exp_d.delete();
      exp_a.delete();
      for (int r = 1; r < nr; r += 2) begin
         for (int b = 0; b < rb; b++) begin
            logic [HL*DW-1:0] word;
            word = '0;
            for (int k = 0; k < HL; k++) begin
               logic signed [DW-1:0] m, c;
               m = rl(lane_of(tile_beats[(r-1)*rb + b], 2*k), relu);
               for (int dr = 0; dr < 2; dr++) begin
                  for (int dl = 0; dl < 2; dl++) begin
                     c = rl(lane_of(tile_beats[(r-1+dr)*rb + b], 2*k + dl), relu);
                     if (c > m) m = c;
                  end
               end
               word[k*DW +: DW] = m;
            end
            exp_d.push_back(word);
            exp_a.push_back(base + ADDR_W'(n));
            n++;
         end
      end
   endtask

   // mode 0: no gaps, always ready; 1: random gaps and random out_rdy;
   // 2: out_rdy held low 10 cycles from the first odd-row beat. abort_at>0: reset after that many odd beats.
   task automatic run_tile(input bit relu, input int rb, input int nr, input logic [ADDR_W-1:0] base,
                           input int mode, input int abort_at);
      int total, idx, odd_acc, cyc, hold, last_acc, n_exp;
      bit done_seen, held;
      total = rb * nr;
      build_expected(relu, rb, nr, base);
      n_exp = exp_d.size();
      obs_d.delete();
      obs_a.delete();
      idx = 0; odd_acc = 0; cyc = 0; hold = 0; last_acc = 0; done_seen = 0; held = 0;

      @(negedge clk);
      start = 1'b1; relu_en = relu; row_beats = 5'(rb); num_rows = 10'(nr); base_addr = base;
      in_vld = 1'b0; out_rdy = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // Config inputs must be ignored once latched.
      relu_en = 1'($urandom); row_beats = 5'($urandom); num_rows = 10'($urandom); base_addr = ADDR_W'($urandom);
      #1 chk("busy_run", busy, 1);

      while (!done_seen && cyc < 4000) begin
         in_vld  = (idx < total) && (mode != 1 || ($urandom % 4) != 0);
         in_data = (idx < total) ? tile_beats[idx] : {4{$urandom()}};
         case (mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = ($urandom % 3) != 0;
            default: out_rdy = (hold == 0);
         endcase
         start = (idx < total) && (($urandom % 8) == 0);
         #1;
         if (out_vld && !out_rdy) chk("bp_in_rdy", in_rdy, 0);
         if (out_vld && out_rdy) begin
            if (exp_d.size() == 0) begin
               chk("extra_out", 1, 0);
            end else begin
               chk("out_data", out_data, exp_d.pop_front());
               chk("out_addr", out_addr, exp_a.pop_front());
            end
            obs_d.push_back(out_data);
            obs_a.push_back(out_addr);
         end
         if (hold > 0) hold--;
         if (in_vld && in_rdy) begin
            if (((idx / rb) % 2) == 1) begin
               odd_acc++;
               if (mode == 2 && !held) begin
                  hold = 10;
                  held = 1;
               end
            end
            idx++;
            last_acc = cyc;
         end
         if (done) begin
            done_seen = 1;
            chk("n_out", obs_d.size(), n_exp);
            chk("exp_left", exp_d.size(), 0);
            if (mode == 0) chk("done_lat", cyc - last_acc, 2);
         end
         cyc++;
         if (abort_at > 0 && odd_acc == abort_at) break;
         @(negedge clk);
      end

      start = 1'b0;
      if (abort_at > 0 && odd_acc == abort_at) begin
         @(negedge clk);
         in_vld = 1'b0; out_rdy = 1'b0; rst = 1'b1;
         #1 chk("abort_vld_pre", out_vld, 1);
         @(negedge clk);
         #1;
         chk("abort_vld", out_vld, 0);
         chk("abort_busy", busy, 0);
         chk("abort_done", done, 0);
         chk("abort_in_rdy", in_rdy, 0);
         rst = 1'b0;
         @(negedge clk);
         #1;
         chk("abort_done2", done, 0);
         chk("abort_vld2", out_vld, 0);
      end else begin
         if (!done_seen) chk("timeout", 0, 1);
         @(negedge clk);
         in_vld = 1'b0;
         #1;
         chk("done_pulse", done, 0);
         chk("busy_idle", busy, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      logic [ADDR_W-1:0] wa [4];
      int rb, nr;
      wa = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

      rst = 1'b1; start = 1'b0; relu_en = 1'b0; row_beats = '0; num_rows = '0; base_addr = '0;
      in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_vld", out_vld, 0);
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_addr", out_addr, 0);
      rst = 1'b0;
      in_vld = 1'b1; out_rdy = 1'b1;
      @(negedge clk);
      #1 chk("idle_in_rdy", in_rdy, 0);
      in_vld = 1'b0;

      // Basic pool
      tile_beats.delete();
      tile_beats.push_back({16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
      tile_beats.push_back({16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8});
      run_tile(0, 1, 2, 12'h010, 0, 0);
      chk("basic_n", obs_d.size(), 1);
      if (obs_d.size() >= 1) begin
         chk("basic_data", obs_d[0], 64'h0008_0006_0006_0008);
         chk("basic_addr", obs_a[0], 12'h010);
      end

      // ReLU on / off
      tile_beats.delete();
      tile_beats.push_back({8{16'hF000}});
      tile_beats.push_back({16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'h0800, 16'hF000, 16'hF000, 16'hF000});
      run_tile(1, 1, 2, 12'h020, 0, 0);
      if (obs_d.size() >= 1) chk("relu_on", obs_d[0], 64'h0000_0000_0800_0000);
      else chk("relu_on_n", obs_d.size(), 1);
      run_tile(0, 1, 2, 12'h020, 0, 0);
      if (obs_d.size() >= 1) chk("relu_off", obs_d[0], 64'hF000_F000_0800_F000);
      else chk("relu_off_n", obs_d.size(), 1);

      // Signed extremes
      tile_beats.delete();
      tile_beats.push_back({96'h0, 16'h7FFF, 16'h8000});
      tile_beats.push_back({96'h0, 16'h8000, 16'h8000});
      run_tile(0, 1, 2, 12'h030, 0, 0);
      if (obs_d.size() >= 1) chk("signed_lane0", obs_d[0][15:0], 16'h7FFF);
      else chk("signed_n", obs_d.size(), 1);

      // Backpressure
      fill_rand(4, 4);
      run_tile(1'($urandom), 4, 4, 12'h100, 2, 0);
      chk("bp_n", obs_a.size(), 8);
      for (int i = 0; i < obs_a.size(); i++) chk("bp_addr", obs_a[i], 12'h100 + 12'(i));

      // Address wrap
      fill_rand(2, 4);
      run_tile(0, 2, 4, 12'hFFE, 0, 0);
      chk("wrap_n", obs_a.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < obs_a.size()) chk("wrap_addr", obs_a[i], wa[i]);
      end

      // Reset mid-tile, then a clean tile
      fill_rand(4, 4);
      run_tile(0, 4, 4, 12'h200, 0, 3);
      fill_rand(4, 4);
      run_tile(1, 4, 4, 12'h300, 0, 0);

      // Full-width rows
      fill_rand(MAX_BEATS, 2);
      run_tile(0, MAX_BEATS, 2, 12'h400, 0, 0);

      // Random tiles
      for (int t = 0; t < 6; t++) begin
         rb = $urandom_range(1, MAX_BEATS);
         nr = 2 * $urandom_range(1, 4);
         fill_rand(rb, nr);
         run_tile(1'($urandom), rb, nr, ADDR_W'($urandom), 1, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
